// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the buffered UART transmitter:
//   - parity mode constants (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - transmit FSM state encoding
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. rd_data always shows the head
//   entry, so a read strobe consumes the word already visible on rd_data.
// Ports
//   clock, reset_n : clock, asynchronous active-low reset
//   wr_en, wr_data : push request and data (ignored while full)
//   rd_en, rd_data : pop request (ignored while empty) and head data
//   full, empty    : occupancy flags derived from the registered count
//   level          : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  // Flags come from the registered count, so a pop in the same cycle
  // never admits a write into a full FIFO.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter: bytes are queued in a FIFO and framed
//   back-to-back (start, DATA_BITS LSB first, optional parity, stop bits)
//   with no idle gap while data is queued. The line level is inverted at the
//   output register when INVERT=1.
// Ports
//   clock, reset_n : clock, asynchronous active-low reset
//   send, txIn     : write strobe and byte captured on the same edge
//   full, empty    : FIFO occupancy flags
//   level          : FIFO occupancy
//   overflow       : one-cycle pulse when a byte is dropped because of full
//   busy           : transmitter FSM is not idle
//   txOut          : registered serial line
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int INVERT       = 0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          send,
  input  logic [DATA_BITS-1:0]          txIn,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          txOut
);

  localparam int   CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic INV   = 1'(INVERT);

  tx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 parity_bit;
  logic                 bit_tick;
  logic                 last_stop;
  logic                 pop;
  logic                 line_bit;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (send),
    .wr_data (txIn),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign bit_tick  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_stop = (bit_idx == 4'(STOP_BITS - 1));
  // Pop either from idle or at the very end of the last stop bit, which is
  // what lets consecutive frames run without a gap.
  assign pop       = !empty && ((state == ST_IDLE) ||
                                (state == ST_STOP && bit_tick && last_stop));
  assign busy      = (state != ST_IDLE);

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_IDLE:   line_bit = 1'b1;
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shift[0];
      ST_PARITY: line_bit = parity_bit;
      ST_STOP:   line_bit = 1'b1;
      default:   line_bit = 1'b1;
    endcase
  end

  // txOut follows the state one cycle later, so the start bit shows up two
  // edges after the write that fed an idle transmitter. Parity is taken at
  // load time because the shift register is consumed during DATA.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      overflow   <= 1'b0;
      txOut      <= ~INV;
    end else begin
      overflow <= send && full;
      txOut    <= line_bit ^ INV;
      if (state != ST_IDLE) bit_cnt <= bit_tick ? '0 : bit_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift      <= fifo_data;
            parity_bit <= (^fifo_data) ^ (PARITY == PARITY_ODD);
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_tick) begin
            shift <= shift >> 1;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) state <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (last_stop) begin
              bit_idx <= '0;
              if (pop) begin
                shift      <= fifo_data;
                parity_bit <= (^fifo_data) ^ (PARITY == PARITY_ODD);
                state      <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Scoreboard bench for uart_tx_fifo with CLKS_PER_BIT=4. Five instances
//   cover 8N1/depth 16, 8N1/depth 4, even parity with two stop bits, odd
//   parity, and an inverted line. Stimulus pushes hand-written frame bit
//   vectors (index 0 = start bit) into a queue; a monitor decodes the
//   selected line mid-bit and compares each frame as it completes.
module tb_uart_tx_fifo;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic [4:0] send_v = '0;
  logic [4:0] full_v, empty_v, ovf_v, busy_v, tx_v;
  logic [4:0] lvl0, lvl2, lvl3, lvl4;
  logic [2:0] lvl1;
  logic [4:0] inv_tab = 5'b10000;

  int     cyc = 0;
  int     sel = 0;
  int     checks = 0;
  int     errors = 0;
  int     frames_seen = 0;
  int     ovf_cnt = 0;
  frame_t exp_q[$];
  int     start_q[$];

  logic        mon_active = 1'b0;
  logic        mon_skip = 1'b0;
  int          mon_ph = 0;
  int          mon_len = 0;
  logic [11:0] mon_bits = '0;
  logic [11:0] mon_exp = '0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .INVERT(0)) u_base (
    .clock(clock), .reset_n(reset_n), .send(send_v[0]), .txIn(txIn),
    .full(full_v[0]), .empty(empty_v[0]), .level(lvl0), .overflow(ovf_v[0]),
    .busy(busy_v[0]), .txOut(tx_v[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .INVERT(0)) u_depth4 (
    .clock(clock), .reset_n(reset_n), .send(send_v[1]), .txIn(txIn),
    .full(full_v[1]), .empty(empty_v[1]), .level(lvl1), .overflow(ovf_v[1]),
    .busy(busy_v[1]), .txOut(tx_v[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(16), .INVERT(0)) u_even2 (
    .clock(clock), .reset_n(reset_n), .send(send_v[2]), .txIn(txIn),
    .full(full_v[2]), .empty(empty_v[2]), .level(lvl2), .overflow(ovf_v[2]),
    .busy(busy_v[2]), .txOut(tx_v[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .INVERT(0)) u_odd (
    .clock(clock), .reset_n(reset_n), .send(send_v[3]), .txIn(txIn),
    .full(full_v[3]), .empty(empty_v[3]), .level(lvl3), .overflow(ovf_v[3]),
    .busy(busy_v[3]), .txOut(tx_v[3]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(16), .INVERT(1)) u_inv (
    .clock(clock), .reset_n(reset_n), .send(send_v[4]), .txIn(txIn),
    .full(full_v[4]), .empty(empty_v[4]), .level(lvl4), .overflow(ovf_v[4]),
    .busy(busy_v[4]), .txOut(tx_v[4]));

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expectFrame(input logic [11:0] bits, input int len);
    frame_t f;
    f.bits = bits;
    f.len  = len;
    exp_q.push_back(f);
  endtask

  // Drives one write on the next cycle; consecutive calls give
  // consecutive write cycles.
  task automatic applyStimulus(input int inst, input logic [7:0] d);
    @(negedge clock);
    send_v       = '0;
    send_v[inst] = 1'b1;
    txIn         = d;
  endtask

  task automatic idleInputs();
    @(negedge clock);
    send_v = '0;
  endtask

  task automatic waitCyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy_v[sel]) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(n < 2000), 32'd1);
  endtask

  // Monitor: hunts for a start bit on the selected line, then samples each
  // bit near its middle and compares the whole frame with the queue head.
  always @(negedge clock) begin
    logic   lb;
    int     idx;
    frame_t f;
    lb = tx_v[sel] ^ inv_tab[sel];
    if (!reset_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (!lb) begin
        mon_active = 1'b1;
        mon_ph     = 0;
        mon_bits   = '0;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame: got start bit at cycle %0d, want none", cyc);
          mon_skip = 1'b1;
          mon_len  = 10;
        end else begin
          f        = exp_q.pop_front();
          mon_skip = 1'b0;
          mon_len  = f.len;
          mon_exp  = f.bits;
        end
      end
    end else begin
      mon_ph++;
      if (((mon_ph - 1) % 4) == 0) begin
        idx = (mon_ph - 1) / 4;
        mon_bits[idx] = lb;
        if (idx == mon_len - 1) begin
          mon_active = 1'b0;
          frames_seen++;
          if (!mon_skip) checkOutput("frame_bits", 32'(mon_bits), 32'(mon_exp));
        end
      end
    end
  end

  always @(negedge clock) if (ovf_v[1]) ovf_cnt++;

  initial begin
    int k;
    int f0;

    // Reset state and an idle line
    repeat (3) @(negedge clock);
    checkOutput("rst_txOut", 32'(tx_v[0]), 32'd1);
    checkOutput("rst_empty", 32'(empty_v[0]), 32'd1);
    checkOutput("rst_full", 32'(full_v[0]), 32'd0);
    checkOutput("rst_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("rst_level", 32'(lvl0), 32'd0);
    checkOutput("rst_overflow", 32'(ovf_v[0]), 32'd0);
    checkOutput("rst_txOut_inv", 32'(tx_v[4]), 32'd0);
    #2 reset_n = 1'b1;
    repeat (30) @(negedge clock);
    checkOutput("idle_txOut", 32'(tx_v[0]), 32'd1);
    checkOutput("idle_empty", 32'(empty_v[0]), 32'd1);
    checkOutput("idle_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("idle_level", 32'(lvl0), 32'd0);
    checkOutput("idle_no_frames", 32'(frames_seen), 32'd0);

    // 8N1 single byte 0xA5: latency, busy window, frame bits
    expectFrame({1'b1, 8'hA5, 1'b0}, 10);
    applyStimulus(0, 8'hA5);
    k = cyc + 1;
    idleInputs();
    checkOutput("busy_before_pop", 32'(busy_v[0]), 32'd0);
    @(negedge clock);
    checkOutput("busy_after_pop", 32'(busy_v[0]), 32'd1);
    waitCyc(k + 40);
    checkOutput("busy_last_cycle", 32'(busy_v[0]), 32'd1);
    @(negedge clock);
    checkOutput("busy_after_frame", 32'(busy_v[0]), 32'd0);
    checkOutput("start_latency", 32'(start_q[start_q.size() - 1] - k), 32'd2);
    waitDone("a5_done");

    // Burst 0x01,0x02,0x03 queued behind a frame in flight
    f0 = start_q.size();
    expectFrame({1'b1, 8'h55, 1'b0}, 10);
    applyStimulus(0, 8'h55);
    k = cyc + 1;
    idleInputs();
    waitCyc(k + 3);
    expectFrame({1'b1, 8'h01, 1'b0}, 10);
    applyStimulus(0, 8'h01);
    expectFrame({1'b1, 8'h02, 1'b0}, 10);
    applyStimulus(0, 8'h02);
    checkOutput("burst_level_1", 32'(lvl0), 32'd1);
    expectFrame({1'b1, 8'h03, 1'b0}, 10);
    applyStimulus(0, 8'h03);
    checkOutput("burst_level_2", 32'(lvl0), 32'd2);
    idleInputs();
    checkOutput("burst_level_3", 32'(lvl0), 32'd3);
    waitDone("burst_done");
    for (int i = 1; i < 4; i++)
      checkOutput("burst_gap", 32'(start_q[f0 + i] - start_q[f0 + i - 1]), 32'd40);
    checkOutput("burst_drained_level", 32'(lvl0), 32'd0);
    checkOutput("burst_drained_empty", 32'(empty_v[0]), 32'd1);

    // Depth 4: five writes while busy, the fifth is dropped
    sel = 1;
    expectFrame({1'b1, 8'h10, 1'b0}, 10);
    applyStimulus(1, 8'h10);
    idleInputs();
    repeat (3) @(negedge clock);
    expectFrame({1'b1, 8'h11, 1'b0}, 10);
    applyStimulus(1, 8'h11);
    expectFrame({1'b1, 8'h12, 1'b0}, 10);
    applyStimulus(1, 8'h12);
    expectFrame({1'b1, 8'h13, 1'b0}, 10);
    applyStimulus(1, 8'h13);
    expectFrame({1'b1, 8'h14, 1'b0}, 10);
    applyStimulus(1, 8'h14);
    applyStimulus(1, 8'h15);
    checkOutput("d4_full", 32'(full_v[1]), 32'd1);
    checkOutput("d4_level", 32'(lvl1), 32'd4);
    checkOutput("d4_no_early_overflow", 32'(ovf_v[1]), 32'd0);
    idleInputs();
    checkOutput("d4_overflow_pulse", 32'(ovf_v[1]), 32'd1);
    @(negedge clock);
    checkOutput("d4_overflow_clear", 32'(ovf_v[1]), 32'd0);
    checkOutput("d4_still_full", 32'(full_v[1]), 32'd1);
    waitDone("d4_done");
    checkOutput("d4_overflow_count", 32'(ovf_cnt), 32'd1);
    checkOutput("d4_level_end", 32'(lvl1), 32'd0);

    // Even parity, two stop bits: 0x07 -> parity 1, 0x03 -> parity 0
    sel = 2;
    f0 = start_q.size();
    expectFrame({2'b11, 1'b1, 8'h07, 1'b0}, 12);
    applyStimulus(2, 8'h07);
    k = cyc + 1;
    expectFrame({2'b11, 1'b0, 8'h03, 1'b0}, 12);
    applyStimulus(2, 8'h03);
    idleInputs();
    waitCyc(k + 96);
    checkOutput("even_busy_last", 32'(busy_v[2]), 32'd1);
    @(negedge clock);
    checkOutput("even_busy_end", 32'(busy_v[2]), 32'd0);
    waitDone("even_done");
    checkOutput("even_gap", 32'(start_q[f0 + 1] - start_q[f0]), 32'd48);
    checkOutput("even_level_end", 32'(lvl2), 32'd0);

    // Odd parity: 0x07 -> parity 0
    sel = 3;
    expectFrame({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    applyStimulus(3, 8'h07);
    idleInputs();
    waitDone("odd_done");
    checkOutput("odd_level_end", 32'(lvl3), 32'd0);

    // Inverted line, then reset mid-DATA aborts everything
    sel = 4;
    checkOutput("inv_idle_low", 32'(tx_v[4]), 32'd0);
    expectFrame({1'b1, 8'h5A, 1'b0}, 10);
    applyStimulus(4, 8'h5A);
    k = cyc + 1;
    expectFrame({1'b1, 8'h3C, 1'b0}, 10);
    applyStimulus(4, 8'h3C);
    idleInputs();
    waitCyc(k + 3);
    checkOutput("inv_start_raw", 32'(tx_v[4]), 32'd1);
    checkOutput("inv_level_queued", 32'(lvl4), 32'd1);
    waitCyc(k + 15);
    f0 = frames_seen;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("inv_reset_line", 32'(tx_v[4]), 32'd0);
    checkOutput("inv_reset_level", 32'(lvl4), 32'd0);
    checkOutput("inv_reset_busy", 32'(busy_v[4]), 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    exp_q.delete();
    repeat (100) @(negedge clock);
    checkOutput("inv_no_frames_after_reset", 32'(frames_seen), 32'(f0));
    checkOutput("inv_line_idle_after_reset", 32'(tx_v[4]), 32'd0);
    checkOutput("inv_empty_after_reset", 32'(empty_v[4]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
